game_controller: RTL and testbench

//  Top-level sequencer for the whack-a-mole game. Runs the game FSM and the 1 Hz game timer.

---
 rtl/game_pkg.sv | 35 +++
 rtl/mole_lfsr.sv | 35 +++
 rtl/game_controller.sv | 172 +++++++++++++++++
 tb/tb_game_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared state encoding, widths and mole-pick helper for the whack-a-mole controller.
package game_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ARM  = ST_ARM,
        PLAY = ST_PLAY,
        OVER = ST_OVER
    } game_state_e;

    localparam int SCORE_W    = 6;
    localparam int TIME_W     = 6;
    localparam int MOLE_IDX_W = 3;

    // Reduce raw LFSR bits to a mole index; bump by one (mod n) when it would repeat.
    function automatic logic [MOLE_IDX_W-1:0] pick_mole_idx(
        input logic [MOLE_IDX_W-1:0] raw,
        input logic [MOLE_IDX_W-1:0] prev,
        input logic                  check_prev,
        input int unsigned           n_moles
    );
        int unsigned idx;
        idx = 32'(raw) % n_moles;
        if (check_prev && (idx == 32'(prev))) begin
            idx = (idx + 1) % n_moles;
        end
        return MOLE_IDX_W'(idx);
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11) that advances only when step_i is high.
module mole_lfsr
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  step_i,
    output logic [MOLE_IDX_W-1:0] rnd_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = lfsr_q;
        if (step_i) begin
            lfsr_d = {lfsr_q[14:0], feedback};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd_o = lfsr_q[MOLE_IDX_W-1:0];

endmodule

// File: rtl/game_controller.sv
// Whack-a-mole sequencer: game FSM, 1 Hz game timer, mole scheduling, hit qualification
// and high-score tracking.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   ARM   | one cycle: reload timer and counters, load first mole
//   PLAY  | game running, moles rotate, hits scored
//   OVER  | game finished, waits for a new start
module game_controller
    import game_pkg::*;
#(
    parameter int          CLK_HZ       = 100_000_000,
    parameter int          GAME_SECONDS = 30,
    parameter int          N_MOLES      = 4,
    parameter int          MOLE_CYCLES  = 75_000_000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                clkIn,
    input  logic                reset,
    input  logic                start_btn,
    input  logic [N_MOLES-1:0]  hit_btn,
    input  logic [SCORE_W-1:0]  score,
    output logic                game_active,
    output logic                timer_expired,
    output logic                player_scored,
    output logic [N_MOLES-1:0]  mole_onehot,
    output logic [TIME_W-1:0]   time_left,
    output logic [SCORE_W-1:0]  high_score
);

    localparam int TICK_W = $clog2(CLK_HZ > 1 ? CLK_HZ : 2);
    localparam int MOLE_W = $clog2(MOLE_CYCLES > 1 ? MOLE_CYCLES : 2);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
    localparam logic [MOLE_W-1:0] MOLE_LAST = MOLE_W'(MOLE_CYCLES - 1);
    localparam logic [TIME_W-1:0] TIME_INIT = TIME_W'(GAME_SECONDS);

    game_state_e            state_q, state_d;
    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [MOLE_W-1:0]      mole_cnt_q, mole_cnt_d;
    logic [TIME_W-1:0]      time_left_q, time_left_d;
    logic [N_MOLES-1:0]     mole_q, mole_d;
    logic [MOLE_IDX_W-1:0]  prev_idx_q, prev_idx_d;
    logic                   expired_q, expired_d;
    logic                   scored_q, scored_d;
    logic [SCORE_W-1:0]     high_q, high_d;

    logic                   lfsr_step;
    logic [MOLE_IDX_W-1:0]  lfsr_rnd;
    logic [MOLE_IDX_W-1:0]  new_idx;
    logic [N_MOLES-1:0]     mole_new;
    logic                   sec_tick;
    logic                   mole_tick;
    logic                   expire;
    logic                   hit_onehot;
    logic                   hit_ok;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_mole_lfsr (
        .clk_i  (clkIn),
        .rst_i  (reset),
        .step_i (lfsr_step),
        .rnd_o  (lfsr_rnd)
    );

    always_comb begin
        sec_tick   = (state_q == PLAY) && (tick_cnt_q == TICK_LAST);
        mole_tick  = (state_q == PLAY) && (mole_cnt_q == MOLE_LAST);
        expire     = sec_tick && (time_left_q <= TIME_W'(1));
        hit_onehot = (hit_btn != '0) && ((hit_btn & (hit_btn - N_MOLES'(1))) == '0);
        hit_ok     = (state_q == PLAY) && (mole_q != '0) && hit_onehot && (hit_btn == mole_q);
        // The first mole of a game has no predecessor to avoid.
        new_idx    = pick_mole_idx(lfsr_rnd, prev_idx_q, state_q == PLAY, N_MOLES);
        mole_new   = N_MOLES'(1) << new_idx;

        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        mole_cnt_d  = mole_cnt_q;
        time_left_d = time_left_q;
        mole_d      = mole_q;
        prev_idx_d  = prev_idx_q;
        expired_d   = 1'b0;
        scored_d    = 1'b0;
        high_d      = high_q;
        lfsr_step   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_btn) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                time_left_d = TIME_INIT;
                tick_cnt_d  = '0;
                mole_cnt_d  = '0;
                mole_d      = mole_new;
                prev_idx_d  = new_idx;
                lfsr_step   = 1'b1;
                state_d     = PLAY;
            end
            PLAY: begin
                tick_cnt_d = sec_tick ? '0 : tick_cnt_q + TICK_W'(1);
                mole_cnt_d = mole_tick ? '0 : mole_cnt_q + MOLE_W'(1);
                if (sec_tick && (time_left_q != '0)) begin
                    time_left_d = time_left_q - TIME_W'(1);
                end
                if (expire) begin
                    time_left_d = '0;
                    mole_d      = '0;
                    expired_d   = 1'b1;
                    state_d     = OVER;
                end else begin
                    if (hit_ok) begin
                        scored_d = 1'b1;
                        mole_d   = '0;
                    end
                    // A mole change in the same cycle as a hit still loads the new mole.
                    if (mole_tick) begin
                        mole_d     = mole_new;
                        prev_idx_d = new_idx;
                        lfsr_step  = 1'b1;
                    end
                end
            end
            OVER: begin
                mole_d = '0;
                if (expired_q && (score > high_q)) begin
                    high_d = score;
                end
                if (start_btn) begin
                    state_d = ARM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            mole_cnt_q  <= '0;
            time_left_q <= TIME_INIT;
            mole_q      <= '0;
            prev_idx_q  <= '0;
            expired_q   <= 1'b0;
            scored_q    <= 1'b0;
            high_q      <= '0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            mole_cnt_q  <= mole_cnt_d;
            time_left_q <= time_left_d;
            mole_q      <= mole_d;
            prev_idx_q  <= prev_idx_d;
            expired_q   <= expired_d;
            scored_q    <= scored_d;
            high_q      <= high_d;
        end
    end

    assign game_active   = (state_q == PLAY);
    assign timer_expired = expired_q;
    assign player_scored = scored_q;
    assign mole_onehot   = mole_q;
    assign time_left     = time_left_q;
    assign high_score    = high_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with a short game (10-cycle second, 3 s, 4-cycle moles).
module tb_game_controller;

    logic       clkIn;
    logic       reset;
    logic       start_btn;
    logic [3:0] hit_btn;
    logic [5:0] score;
    logic       game_active;
    logic       timer_expired;
    logic       player_scored;
    logic [3:0] mole_onehot;
    logic [5:0] time_left;
    logic [5:0] high_score;

    int n_pass  = 0;
    int n_total = 0;

    game_controller #(
        .CLK_HZ       (10),
        .GAME_SECONDS (3),
        .N_MOLES      (4),
        .MOLE_CYCLES  (4),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clkIn         (clkIn),
        .reset         (reset),
        .start_btn     (start_btn),
        .hit_btn       (hit_btn),
        .score         (score),
        .game_active   (game_active),
        .timer_expired (timer_expired),
        .player_scored (player_scored),
        .mole_onehot   (mole_onehot),
        .time_left     (time_left),
        .high_score    (high_score)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    typedef struct packed {
        logic       start;
        logic [3:0] hit;
        logic [5:0] score;
        logic       exp_act;
        logic       exp_exp;
        logic       exp_sc;
        logic [3:0] exp_mole;
        logic [5:0] exp_time;
        logic [5:0] exp_high;
    } vec_t;

    vec_t       tv [34];
    logic [3:0] mole_seq [8];

    task automatic cyc();
        @(posedge clkIn);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic act, input logic expd, input logic sc,
                           input logic [3:0] mole, input logic [5:0] tl, input logic [5:0] hs);
        chk({tag, "_active"}, game_active, act);
        chk({tag, "_expired"}, timer_expired, expd);
        chk({tag, "_scored"}, player_scored, sc);
        chk({tag, "_mole"}, mole_onehot, mole);
        chk({tag, "_time"}, time_left, tl);
        chk({tag, "_high"}, high_score, hs);
    endtask

    // One full game without hits; moles sampled once per mole period must never repeat.
    task automatic play_game(input logic [5:0] sc, input logic [5:0] exp_high);
        int         p;
        logic [3:0] prev;
        score     = sc;
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        cyc();
        p    = 0;
        prev = '0;
        while (game_active && p < 40) begin
            if (p % 4 == 0) begin
                chk("mole_onehot_valid", $onehot(mole_onehot), 1);
                if (p > 0) chk("mole_repeat", mole_onehot == prev, 0);
                prev = mole_onehot;
            end
            p++;
            cyc();
        end
        chk("play_len", p, 30);
        chk("expire_pulse", timer_expired, 1);
        cyc();
        chk("expire_clear", timer_expired, 0);
        chk("high_score", high_score, exp_high);
    endtask

    initial begin
        reset     = 1'b1;
        start_btn = 1'b0;
        hit_btn   = '0;
        score     = '0;

        mole_seq[0] = 4'b0010; mole_seq[1] = 4'b1000;
        mole_seq[2] = 4'b0001; mole_seq[3] = 4'b1000;
        mole_seq[4] = 4'b0100; mole_seq[5] = 4'b0001;
        mole_seq[6] = 4'b0010; mole_seq[7] = 4'b0100;

        for (int r = 0; r < 34; r++) begin
            tv[r]       = '0;
            tv[r].score = 6'd5;
        end
        tv[0].start    = 1'b1;
        tv[0].exp_time = 6'd3;
        for (int p = 0; p < 30; p++) begin
            tv[p+1].exp_act  = 1'b1;
            tv[p+1].exp_time = 6'(3 - p / 10);
            tv[p+1].exp_mole = mole_seq[p / 4];
        end
        // valid hit, then repeat hit against a cleared mole
        tv[3].hit = 4'b0010;  tv[3].exp_sc = 1'b1;  tv[3].exp_mole = 4'b0000;
        tv[4].hit = 4'b0010;  tv[4].exp_mole = 4'b0000;
        // wrong bit, multi-bit cover, then hit on the mole-change cycle
        tv[7].hit = 4'b0100;
        tv[8].hit = 4'b1100;
        tv[9].hit = 4'b1000;  tv[9].exp_sc = 1'b1;
        tv[12].start = 1'b1;
        tv[19].hit = 4'b0001;
        tv[23].hit = 4'b0001; tv[23].exp_sc = 1'b1; tv[23].exp_mole = 4'b0000;
        tv[24].exp_mole = 4'b0000;
        // valid hit on the expiry cycle loses to expiry
        tv[31].hit = 4'b0100; tv[31].exp_exp = 1'b1;
        tv[32].exp_high = 6'd5;
        tv[33].exp_high = 6'd5;

        cyc();
        cyc();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 4'b0000, 6'd3, 6'd0);
        reset = 1'b0;

        for (int i = 0; i < 50; i++) begin
            hit_btn = 4'(1 << (i % 4));
            cyc();
            chk("idle_active", game_active, 0);
            chk("idle_scored", player_scored, 0);
        end
        hit_btn = '0;
        cyc();
        chk_all("idle", 1'b0, 1'b0, 1'b0, 4'b0000, 6'd3, 6'd0);

        for (int r = 0; r < 34; r++) begin
            start_btn = tv[r].start;
            hit_btn   = tv[r].hit;
            score     = tv[r].score;
            cyc();
            chk_all($sformatf("row%0d", r), tv[r].exp_act, tv[r].exp_exp, tv[r].exp_sc,
                    tv[r].exp_mole, tv[r].exp_time, tv[r].exp_high);
        end
        start_btn = 1'b0;
        hit_btn   = '0;

        play_game(6'd3, 6'd5);
        play_game(6'd7, 6'd7);
        play_game(6'd2, 6'd7);

        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        repeat (10) cyc();
        chk("midgame_active", game_active, 1);
        reset     = 1'b1;
        start_btn = 1'b1;
        hit_btn   = mole_onehot;
        cyc();
        chk_all("midreset", 1'b0, 1'b0, 1'b0, 4'b0000, 6'd3, 6'd0);
        reset     = 1'b0;
        start_btn = 1'b0;
        hit_btn   = '0;
        cyc();
        chk_all("post_reset", 1'b0, 1'b0, 1'b0, 4'b0000, 6'd3, 6'd0);
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        chk("reseed_arm_active", game_active, 0);
        cyc();
        chk("reseed_active", game_active, 1);
        chk("reseed_first_mole", mole_onehot, 4'b0010);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
